fpga_ps_loader: RTL and testbench

- Z80-side passive-serial configuration shifter for the GS FPGA.
- Sits between the Z80 I/O bus and the FPGA DCLK/DATA0 pins, alongside the CPLD that drives config_n and buffers status_n/conf_done.
- The Z80 pulses config_n, polls status_n, then writes configuration bytes to a port; this block serialises each byte LSB-first onto DATA0 with DCLK, and reports busy/overrun/status for polling.

---
 rtl/fpga_ps_loader_if.sv | 23 ++
 rtl/fpga_ps_loader.sv | 150 +++++++++++++++
 tb/tb_fpga_ps_loader.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpga_ps_loader_if.sv
// Z80 I/O bus slice seen by the passive-serial loader.
//   master : Z80 side, drives strobes, address bits a7/a6 and write data.
//   slave  : loader side, returns the status byte and its output enable.
interface fpga_ps_loader_if;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic       a6;
  logic       a7;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;

  modport master (
    output iorq_n, rd_n, wr_n, a6, a7, d_in,
    input  d_out, d_oe
  );

  modport slave (
    input  iorq_n, rd_n, wr_n, a6, a7, d_in,
    output d_out, d_oe
  );
endinterface

// File: rtl/fpga_ps_loader.sv
// Z80-side passive-serial configuration shifter for the GS FPGA.
// Each byte the Z80 writes to the port is shifted LSB-first onto DATA0 with DCLK.
// Reads of the same port return {busy, overrun, 0000, conf_done, status_n}.
// Ports:
//   clkin, coldres_n   : Z80 clock (rising edge) and async active-low reset
//   bus (slave)        : iorq_n/rd_n/wr_n/a7/a6/d_in in, d_out/d_oe out
//                        (d_out/d_oe are combinational)
//   status_n, conf_done: FPGA status, status_n already synchronous to clkin
//   dclk, data0        : FPGA configuration clock and data
//   busy               : high while a byte is being shifted
module fpga_ps_loader #(
  parameter logic [1:0]  PORT_A76 = 2'b11,
  parameter int unsigned DIV      = 1
) (
  input  logic              clkin,
  input  logic              coldres_n,
  fpga_ps_loader_if.slave   bus,
  input  logic              status_n,
  input  logic              conf_done,
  output logic              dclk,
  output logic              data0,
  output logic              busy
);

  localparam int unsigned CNT_W    = 3;
  localparam int unsigned BYTE_W   = 8;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } state_t;

  state_t            state;
  logic [BYTE_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  div_cnt;
  logic              overrun;
  logic              wr_prev;
  logic              rd_prev;

  logic sel;
  logic wr_now;
  logic rd_now;
  logic load;
  logic rd_edge;

  // Port decode and one-shot strobes: one event per bus cycle regardless of length.
  always_comb begin
    sel     = ({bus.a7, bus.a6} == PORT_A76) && !bus.iorq_n;
    wr_now  = sel && !bus.wr_n;
    rd_now  = sel && !bus.rd_n;
    load    = wr_now && !wr_prev;
    rd_edge = rd_now && !rd_prev;
  end

  // Status read path.
  assign bus.d_oe  = rd_now;
  assign bus.d_out = {busy, overrun, 4'b0000, conf_done, status_n};

  // Shifter FSM, strobe history and sticky overrun flag.
  always_ff @(posedge clkin or negedge coldres_n) begin
    if (!coldres_n) begin
      state   <= IDLE;
      shift_q <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      overrun <= 1'b0;
      wr_prev <= 1'b0;
      rd_prev <= 1'b0;
      dclk    <= 1'b0;
      data0   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      wr_prev <= wr_now;
      rd_prev <= rd_now;

      // A rejected write outranks a simultaneous read-clear.
      if (load && ((state != IDLE) || !status_n)) begin
        overrun <= 1'b1;
      end else if (rd_edge) begin
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (load && status_n) begin
            shift_q <= bus.d_in;
            data0   <= bus.d_in[0];
            busy    <= 1'b1;
            bit_cnt <= '0;
            div_cnt <= '0;
            dclk    <= 1'b0;
            state   <= LOW;
          end
        end

        LOW: begin
          if (!status_n) begin
            // FPGA dropped nSTATUS: stop clocking, keep the shift register.
            state   <= IDLE;
            dclk    <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dclk    <= 1'b1;
            state   <= HIGH;
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        HIGH: begin
          if (!status_n) begin
            state   <= IDLE;
            dclk    <= 1'b0;
            busy    <= 1'b0;
            bit_cnt <= '0;
            div_cnt <= '0;
          end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            dclk    <= 1'b0;
            if (bit_cnt == BIT_LAST) begin
              // data0 keeps the last bit while idle.
              busy    <= 1'b0;
              bit_cnt <= '0;
              state   <= IDLE;
            end else begin
              shift_q <= {1'b0, shift_q[BYTE_W-1:1]};
              data0   <= shift_q[1];
              bit_cnt <= bit_cnt + CNT_W'(1);
              state   <= LOW;
            end
          end else begin
            div_cnt <= div_cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_ps_loader.sv
// Directed bench for fpga_ps_loader: a DIV=1 and a DIV=3 instance share the Z80 bus stimulus.
module tb_fpga_ps_loader;

  logic       clkin = 1'b0;
  logic       coldres_n = 1'b0;
  logic       iorq_n = 1'b1;
  logic       rd_n = 1'b1;
  logic       wr_n = 1'b1;
  logic       a7 = 1'b0;
  logic       a6 = 1'b0;
  logic [7:0] d_in = 8'h00;
  logic       status_n = 1'b1;
  logic       conf_done = 1'b0;

  logic dclk1, data0_1, busy1;
  logic dclk3, data0_3, busy3;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clkin = ~clkin;

  fpga_ps_loader_if bus1 ();
  fpga_ps_loader_if bus3 ();

  assign bus1.iorq_n = iorq_n;
  assign bus1.rd_n   = rd_n;
  assign bus1.wr_n   = wr_n;
  assign bus1.a7     = a7;
  assign bus1.a6     = a6;
  assign bus1.d_in   = d_in;
  assign bus3.iorq_n = iorq_n;
  assign bus3.rd_n   = rd_n;
  assign bus3.wr_n   = wr_n;
  assign bus3.a7     = a7;
  assign bus3.a6     = a6;
  assign bus3.d_in   = d_in;

  fpga_ps_loader #(.PORT_A76(2'b11), .DIV(1)) dut1 (
    .clkin     (clkin),
    .coldres_n (coldres_n),
    .bus       (bus1),
    .status_n  (status_n),
    .conf_done (conf_done),
    .dclk      (dclk1),
    .data0     (data0_1),
    .busy      (busy1)
  );

  fpga_ps_loader #(.PORT_A76(2'b11), .DIV(3)) dut3 (
    .clkin     (clkin),
    .coldres_n (coldres_n),
    .bus       (bus3),
    .status_n  (status_n),
    .conf_done (conf_done),
    .dclk      (dclk3),
    .data0     (data0_3),
    .busy      (busy3)
  );

  // DCLK rise counter and LSB-first capture of data0 at each rise (DIV=1 instance).
  logic       mon_clr = 1'b0;
  logic       dclk1_prev = 1'b0;
  int         rises1 = 0;
  logic [7:0] rx1 = 8'h00;

  always @(posedge clkin) begin
    if (mon_clr) begin
      rises1 <= 0;
      rx1    <= 8'h00;
    end else if (dclk1 && !dclk1_prev) begin
      rises1 <= rises1 + 1;
      rx1    <= {data0_1, rx1[7:1]};
    end
    dclk1_prev <= dclk1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
    a7     = 1'b0;
    a6     = 1'b0;
    d_in   = 8'h00;
  endtask

  // Write cycle starting at a negedge; returns at the negedge after `len` clkin edges.
  task automatic iowr(input logic [1:0] a76, input logic iorq_lvl, input logic [7:0] d, input int len);
    {a7, a6} = a76;
    d_in     = d;
    iorq_n   = iorq_lvl;
    wr_n     = 1'b0;
    repeat (len) @(negedge clkin);
    bus_idle();
  endtask

  // Read cycle: sample the combinational read data, then leave a gap cycle.
  task automatic iord(input logic [1:0] a76, output logic [7:0] d, output logic oe);
    {a7, a6} = a76;
    iorq_n   = 1'b0;
    rd_n     = 1'b0;
    #1;
    d  = bus1.d_out;
    oe = bus1.d_oe;
    @(negedge clkin);
    bus_idle();
    @(negedge clkin);
  endtask

  task automatic wait_idle1(input int maxc);
    int n;
    n = 0;
    while (busy1 && n < maxc) begin
      @(negedge clkin);
      n++;
    end
    chk("busy1_timeout", 32'(busy1), 32'd0);
  endtask

  task automatic mon_reset();
    mon_clr = 1'b1;
    @(negedge clkin);
    mon_clr = 1'b0;
  endtask

  initial begin
    logic [7:0] rd_v;
    logic       oe_v;
    logic [7:0] byte_v;

    bus_idle();
    repeat (3) @(negedge clkin);

    // Reset state and read path while held in reset.
    chk("rst_dclk1",  32'(dclk1),   32'd0);
    chk("rst_data0_1", 32'(data0_1), 32'd0);
    chk("rst_busy1",  32'(busy1),   32'd0);
    chk("rst_dclk3",  32'(dclk3),   32'd0);
    chk("rst_doe_idle", 32'(bus1.d_oe), 32'd0);
    iord(2'b11, rd_v, oe_v);
    chk("rst_rd_oe",  32'(oe_v), 32'd1);
    chk("rst_rd_val", 32'(rd_v), 32'h01);
    conf_done = 1'b1;
    status_n  = 1'b0;
    iord(2'b11, rd_v, oe_v);
    chk("rst_rd_val2", 32'(rd_v), 32'h02);
    conf_done = 1'b0;
    status_n  = 1'b1;
    coldres_n = 1'b1;
    @(negedge clkin);

    // Single byte $A5 at DIV=1, cycle by cycle.
    mon_reset();
    byte_v = 8'hA5;
    iowr(2'b11, 1'b0, byte_v, 1);
    for (int k = 0; k < 16; k++) begin
      chk("a5_dclk",  32'(dclk1),   32'(k % 2));
      chk("a5_data0", 32'(data0_1), 32'(byte_v[k/2]));
      chk("a5_busy",  32'(busy1),   32'd1);
      @(negedge clkin);
    end
    chk("a5_busy_end",  32'(busy1),   32'd0);
    chk("a5_dclk_end",  32'(dclk1),   32'd0);
    chk("a5_data0_end", 32'(data0_1), 32'd1);
    chk("a5_rises",     32'(rises1),  32'd8);
    chk("a5_rx",        32'(rx1),     32'hA5);

    // Overrun: second write 4 cycles into the first byte is dropped.
    mon_reset();
    iowr(2'b11, 1'b0, 8'h3C, 1);
    repeat (3) @(negedge clkin);
    iowr(2'b11, 1'b0, 8'hFF, 1);
    wait_idle1(40);
    chk("ovr_rises", 32'(rises1),  32'd8);
    chk("ovr_rx",    32'(rx1),     32'h3C);
    chk("ovr_data0", 32'(data0_1), 32'd0);
    iord(2'b11, rd_v, oe_v);
    chk("ovr_rd1", 32'(rd_v), 32'h41);
    iord(2'b11, rd_v, oe_v);
    chk("ovr_rd2", 32'(rd_v), 32'h01);

    // Abort on status_n low after three DCLK rises.
    mon_reset();
    iowr(2'b11, 1'b0, 8'hFF, 1);
    repeat (5) @(negedge clkin);
    chk("abt_dclk_pre", 32'(dclk1), 32'd1);
    status_n = 1'b0;
    @(negedge clkin);
    chk("abt_dclk", 32'(dclk1), 32'd0);
    chk("abt_busy", 32'(busy1), 32'd0);
    repeat (8) @(negedge clkin);
    chk("abt_rises", 32'(rises1), 32'd3);
    iowr(2'b11, 1'b0, 8'h55, 1);
    chk("abt_wr_busy", 32'(busy1), 32'd0);
    repeat (4) @(negedge clkin);
    chk("abt_wr_rises", 32'(rises1), 32'd3);
    iord(2'b11, rd_v, oe_v);
    chk("abt_rd", 32'(rd_v), 32'h40);
    status_n = 1'b1;
    iord(2'b11, rd_v, oe_v);
    chk("abt_rd2", 32'(rd_v), 32'h01);

    // Reset mid-byte stops DCLK immediately.
    mon_reset();
    iowr(2'b11, 1'b0, 8'hFF, 1);
    repeat (3) @(negedge clkin);
    chk("mrst_dclk_pre", 32'(dclk1), 32'd1);
    coldres_n = 1'b0;
    #1;
    chk("mrst_dclk",  32'(dclk1),   32'd0);
    chk("mrst_data0", 32'(data0_1), 32'd0);
    chk("mrst_busy",  32'(busy1),   32'd0);
    repeat (4) @(negedge clkin);
    chk("mrst_rises", 32'(rises1), 32'd1);
    coldres_n = 1'b1;
    @(negedge clkin);

    // Long write yields exactly one byte.
    mon_reset();
    iowr(2'b11, 1'b0, 8'hC3, 6);
    wait_idle1(40);
    chk("long_rises", 32'(rises1), 32'd8);
    chk("long_rx",    32'(rx1),    32'hC3);
    iord(2'b11, rd_v, oe_v);
    chk("long_rd", 32'(rd_v), 32'h01);

    // Decode: other port and memory write are ignored; foreign read not driven.
    mon_reset();
    iowr(2'b10, 1'b0, 8'hC3, 3);
    repeat (4) @(negedge clkin);
    chk("dec80_busy",  32'(busy1),  32'd0);
    chk("dec80_rises", 32'(rises1), 32'd0);
    iowr(2'b11, 1'b1, 8'hC3, 3);
    repeat (4) @(negedge clkin);
    chk("decmem_busy",  32'(busy1),  32'd0);
    chk("decmem_rises", 32'(rises1), 32'd0);
    iord(2'b10, rd_v, oe_v);
    chk("dec80_rd_oe", 32'(oe_v), 32'd0);
    iord(2'b11, rd_v, oe_v);
    chk("dec_rd", 32'(rd_v), 32'h01);

    // DIV=3 instance: 3-cycle phases, 48-cycle byte.
    coldres_n = 1'b0;
    @(negedge clkin);
    coldres_n = 1'b1;
    @(negedge clkin);
    iowr(2'b11, 1'b0, 8'h01, 1);
    for (int k = 0; k < 48; k++) begin
      chk("d3_dclk",  32'(dclk3),   32'((k / 3) % 2));
      chk("d3_data0", 32'(data0_3), (k < 6) ? 32'd1 : 32'd0);
      chk("d3_busy",  32'(busy3),   32'd1);
      @(negedge clkin);
    end
    chk("d3_busy_end", 32'(busy3), 32'd0);
    chk("d3_dclk_end", 32'(dclk3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
